// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter
//   Merges the debounced press pulses of N_BUTTONS ButtonHandler channels into
//   one ordered command stream. Each press is latched in a per-button pending
//   flag. Pending buttons are granted round-robin over a valid/ready handshake.
//
//   Optional feature: define BTN_AUTOREPEAT_EN to add per-button hold counters.
//   A held button then re-issues commands marked cmd_repeat=1.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_pulse    : one-cycle press pulse per button
//   btn_state    : debounced level per button (used only with BTN_AUTOREPEAT_EN)
//   cmd_valid    : command offered (registered)
//   cmd_ready    : downstream accepts command
//   cmd_id       : granted button index
//   cmd_repeat   : offered command is an auto-repeat
//   cmd_dropped  : one-cycle pulse, a press arrived on an already-pending button
module button_cmd_arbiter #(
  parameter int N_BUTTONS     = 5,
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100,
  localparam int ID_W         = $clog2(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_pulse,
  input  logic [N_BUTTONS-1:0] btn_state,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [ID_W-1:0]      cmd_id,
  output logic                 cmd_repeat,
  output logic                 cmd_dropped
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                state;
  logic [N_BUTTONS-1:0]  pending, pend_nx;
  logic [N_BUTTONS-1:0]  rep, rep_nx;
  logic [N_BUTTONS-1:0]  grant_clr;
  logic [N_BUTTONS-1:0]  rpt_fire;
  logic [ID_W-1:0]       last_idx;
  logic [ID_W-1:0]       win_idx;
  logic                  win_found;
  logic                  drop_nx;
  logic                  hs;

  assign hs = (state == OFFER) && cmd_valid && cmd_ready;

  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++)
      grant_clr[i] = hs && (cmd_id == ID_W'(i));
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [N_BUTTONS-1:0] armed;
  logic [CNT_W-1:0]     hold_cnt [N_BUTTONS];

  // cnt holds the number of held cycles seen so far; a fire happens on the
  // cycle that would bring it to HOLD_CYCLES. After a fire it is rewound so
  // the next fire comes REPEAT_CYCLES held cycles later.
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++)
      rpt_fire[i] = armed[i] && btn_state[i] && !btn_pulse[i] &&
                    (hold_cnt[i] == CNT_W'(HOLD_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= '0;
      for (int i = 0; i < N_BUTTONS; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (btn_pulse[i]) begin
          armed[i]    <= 1'b1;
          hold_cnt[i] <= '0;
        end else if (armed[i] && btn_state[i]) begin
          hold_cnt[i] <= rpt_fire[i] ? CNT_W'(HOLD_CYCLES - REPEAT_CYCLES)
                                     : hold_cnt[i] + CNT_W'(1);
        end else begin
          armed[i]    <= 1'b0;
          hold_cnt[i] <= '0;
        end
      end
    end
  end
`else
  logic unused_btn_state;
  assign unused_btn_state = ^btn_state;
  assign rpt_fire         = '0;
`endif

  // Pending/rep update. A press on an already-pending button is dropped unless
  // that button is being granted this very cycle, in which case the new press
  // survives the grant's clear. Repeats merge silently into a pending bit.
  always_comb begin
    pend_nx = pending;
    rep_nx  = rep;
    drop_nx = 1'b0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (btn_pulse[i]) begin
        if (pending[i] && !grant_clr[i]) begin
          drop_nx = 1'b1;
        end else begin
          pend_nx[i] = 1'b1;
          rep_nx[i]  = 1'b0;
        end
      end else if (rpt_fire[i]) begin
        if (!pending[i] || grant_clr[i]) begin
          pend_nx[i] = 1'b1;
          rep_nx[i]  = 1'b1;
        end
      end else if (grant_clr[i]) begin
        pend_nx[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int off = 0; off < N_BUTTONS; off++) begin
      idx = int'(last_idx) + 1 + off;
      if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_id      <= '0;
      cmd_repeat  <= 1'b0;
      cmd_dropped <= 1'b0;
      last_idx    <= ID_W'(N_BUTTONS - 1);
      pending     <= '0;
      rep         <= '0;
    end else begin
      pending     <= pend_nx;
      rep         <= rep_nx;
      cmd_dropped <= drop_nx;
      case (state)
        IDLE: begin
          if (win_found) begin
            cmd_id     <= win_idx;
`ifdef BTN_AUTOREPEAT_EN
            cmd_repeat <= rep[win_idx];
`else
            cmd_repeat <= 1'b0;
`endif
            cmd_valid  <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            last_idx  <= cmd_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Scoreboard bench for button_cmd_arbiter (N_BUTTONS=5, HOLD=20, REPEAT=10).
// Stimulus pushes expected commands into a queue; a forked monitor pops and
// compares on every accepted handshake.
module tb_button_cmd_arbiter;
  localparam int N    = 5;
  localparam int HOLD = 20;
  localparam int REP  = 10;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    btn_pulse = '0;
  logic [N-1:0]    btn_state = '0;
  logic            cmd_ready = 1'b0;
  logic            cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_repeat;
  logic            cmd_dropped;

  button_cmd_arbiter #(.N_BUTTONS(N), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse), .btn_state(btn_state),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_repeat(cmd_repeat), .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            rep;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, hs_cnt = 0, drop_cnt = 0;
  int h0, d0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input int id, input logic r);
    exp_t e;
    e.id  = ID_W'(id);
    e.rep = r;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    btn_pulse = m;
    tick();
    btn_pulse = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; btn_pulse = '0; btn_state = '0; cmd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (q.size() != 0 || cmd_valid); i++) tick();
    repeat (4) tick();
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && cmd_valid && cmd_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got id %0d rep %0d expected none", cmd_id, cmd_repeat);
          end else begin
            e = q.pop_front();
            check("sb_cmd_id", int'(cmd_id), int'(e.id));
            check("sb_cmd_repeat", int'(cmd_repeat), int'(e.rep));
          end
        end
        if (rst_n && cmd_dropped) drop_cnt++;
      end
    join_none

    // Reset state
    tick();
    check("rst_valid", cmd_valid, 0);
    check("rst_id", cmd_id, 0);
    check("rst_repeat", cmd_repeat, 0);
    check("rst_dropped", cmd_dropped, 0);
    rst_n = 1'b1;
    tick();

    // Single press on button 2, latency k+2, gone at k+3
    cmd_ready = 1'b1;
    expect_cmd(2, 1'b0);
    btn_pulse = 5'b00100;
    tick();
    btn_pulse = '0;
    check("lat_k1_valid", cmd_valid, 0);
    tick();
    check("lat_k2_valid", cmd_valid, 1);
    check("lat_k2_id", cmd_id, 2);
    check("lat_k2_repeat", cmd_repeat, 0);
    tick();
    check("lat_k3_valid", cmd_valid, 0);
    drain();

    // Round-robin: 1,3 then 4,1
    do_reset();
    cmd_ready = 1'b1;
    expect_cmd(1, 1'b0);
    expect_cmd(3, 1'b0);
    pulse(5'b01010);
    drain();
    expect_cmd(4, 1'b0);
    expect_cmd(1, 1'b0);
    pulse(5'b10010);
    drain();

    // Backpressure with a dropped second press
    do_reset();
    cmd_ready = 1'b0;
    h0 = hs_cnt;
    d0 = drop_cnt;
    expect_cmd(0, 1'b0);
    pulse(5'b00001);
    tick();
    check("bp_offer_valid", cmd_valid, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) btn_pulse = 5'b00001;
      tick();
      btn_pulse = '0;
      check("bp_dropped", cmd_dropped, (i == 3) ? 1 : 0);
      check("bp_valid", cmd_valid, 1);
      check("bp_id", cmd_id, 0);
    end
    cmd_ready = 1'b1;
    drain();
    check("bp_drop_count", drop_cnt - d0, 1);
    check("bp_cmd_count", hs_cnt - h0, 1);

    // Long press on button 4, held 55 cycles
    do_reset();
    cmd_ready = 1'b1;
    h0 = hs_cnt;
    expect_cmd(4, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) expect_cmd(4, 1'b1);
`endif
    btn_state = 5'b10000;
    pulse(5'b10000);
    repeat (55) tick();
    btn_state = '0;
    drain();
`ifdef BTN_AUTOREPEAT_EN
    check("long_cmd_count", hs_cnt - h0, 5);
`else
    check("long_cmd_count", hs_cnt - h0, 1);
`endif

    // Early release at held cycle 15: no repeats
    h0 = hs_cnt;
    expect_cmd(4, 1'b0);
    btn_state = 5'b10000;
    pulse(5'b10000);
    repeat (14) tick();
    btn_state = '0;
    repeat (40) tick();
    drain();
    check("short_cmd_count", hs_cnt - h0, 1);

    // Reset during OFFER with three bits pending
    do_reset();
    cmd_ready = 1'b0;
    pulse(5'b00111);
    tick();
    check("rstoff_offer_valid", cmd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstoff_valid", cmd_valid, 0);
    check("rstoff_id", cmd_id, 0);
    check("rstoff_repeat", cmd_repeat, 0);
    check("rstoff_dropped", cmd_dropped, 0);
    tick(); tick();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    h0 = hs_cnt;
    repeat (30) tick();
    check("rstoff_no_cmds", hs_cnt - h0, 0);
    check("rstoff_idle_valid", cmd_valid, 0);
    expect_cmd(1, 1'b0);
    pulse(5'b00010);
    drain();
    check("rstoff_new_cmd", hs_cnt - h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
